vga_text_vram: RTL and testbench
================================

// Module: vga_text_vram
// PURPOSE
//   Text-mode VRAM (segment B800, 80x25 cells, 16-bit ASCII+attribute words) serving both ends of the display path.
//   Answers character fetches from vga_controller (vram_addr -> vram_data) with fixed latency and top priority.
//   Accepts CPU reads/writes from memory_controller via a req/ack handshake, in display-free slots only.
//   Clears the screen to CLEAR_WORD after every reset.
// PARAMETERS
//   ADDR_W      11        word address width; depth 2**ADDR_W (2048 >= 2000 cells)
//   CLEAR_WORD  16'h0720  fill value: space, light grey on black
// PORTS
//   clk_vga     in   1       single clock for the whole block (pixel clock domain)
//   rst_n       in   1       asynchronous, active-low reset
//   disp_req    in   1       display fetch strobe; disp_addr valid this cycle
//   disp_addr   in   ADDR_W  display word address (vga_controller vram_addr)
//   disp_data   out  16      fetched word (vga_controller vram_data)
//   disp_valid  out  1       disp_data valid, one-cycle pulse per fetch
//   cpu_req     in   1       CPU access request; held until cpu_ack seen
//   cpu_we      in   1       1 = write, 0 = read
//   cpu_addr    in   ADDR_W  CPU word address
//   cpu_be      in   2       write byte enables; [0]=low (ASCII), [1]=high (attr)
//   cpu_wdata   in   16      write data
//   cpu_rdata   out  16      read data, valid when cpu_ack=1; holds last read value
//   cpu_ack     out  1       one-cycle completion pulse
//   clearing    out  1       1 while post-reset clear sweep runs
// BEHAVIOUR
//   - Reset values: disp_data=0, disp_valid=0, cpu_rdata=0, cpu_ack=0, clearing=1, CPU FSM=IDLE, clear ptr=0.
//   - Storage: single-port synchronous RAM, 1 access/cycle, 1-cycle read latency. RAM contents are not reset.
//   - Slot priority per cycle: clear sweep > display fetch > CPU access.
//   - Display: disp_req in cycle N samples disp_addr; disp_data/disp_valid presented in N+2, always, independent
//     of CPU traffic. Back-to-back fetches every cycle are supported (fully pipelined).
//   - While clearing=1 the display is still answered at N+2, with disp_data=CLEAR_WORD and no RAM access.
//   - Clear sweep: starts on reset deassertion; writes CLEAR_WORD to addresses 0..2**ADDR_W-1, one per cycle;
//     clearing drops after the last write (clearing high exactly 2**ADDR_W cycles).
//   - CPU FSM: IDLE -> PEND -> WAIT -> RESP -> IDLE.
//     IDLE: if cpu_req=1 and clearing=0, capture we/addr/be/wdata; go PEND. Otherwise stay.
//     PEND: if disp_req=0 and clearing=0, issue RAM access (write or read); go WAIT. Else stay PEND.
//     WAIT: read: load cpu_rdata from RAM output. Write: nothing. Go RESP.
//     RESP: cpu_ack=1 for this cycle only; go IDLE.
//   - Minimum CPU latency: req sampled in cycle 0 -> cpu_ack in cycle 3; each cycle with disp_req=1 in PEND adds 1.
//   - Requester keeps cpu_req high through the ack cycle; cpu_req high in the IDLE cycle after RESP is a new request.
//   - Writes honour cpu_be per byte; cpu_be=2'b00 performs no RAM update but is still acked normally.
//   - Captured request registers are stable from IDLE to RESP; cpu_* input changes after capture are ignored.
//   - Ordering: a write acked in cycle T is visible to any display fetch sampled in cycle >= T.
//   - Address wrap: addresses are ADDR_W bits; no range check (cells 2000..2047 are plain storage).
//   - Reset mid-operation: FSM to IDLE, pending access dropped (no ack), in-flight disp_valid suppressed,
//     clear sweep restarts from address 0.
// TESTING
//   1. Release reset -> clearing=1 for exactly 2048 cycles; then disp_req at 0x000,0x7CF -> disp_data 0x0720 at N+2.
//   2. CPU write addr 0x005 data 0x1F41 be=11, no display traffic -> cpu_ack at cycle 3; display fetch 0x005 -> 0x1F41.
//   3. Then CPU write 0x005 data 0x2242 be=01 -> CPU read 0x005 returns cpu_rdata=0x1F42 with ack at cycle 3.
//   4. CPU read pending, disp_req held high 5 cycles -> disp_valid 5 consecutive cycles, cpu_ack at cycle 8.
//   5. cpu_req raised during clear sweep -> no capture, no ack until clearing=0; then ack 3 cycles after capture.
//   6. Assert rst_n=0 while FSM in PEND -> cpu_ack never pulses; on release clearing=1 and sweep restarts at 0.

Source files
------------

// File: rtl/vga_text_vram.sv
// Text-mode VRAM for an 80x25 character display. Display fetches get a fixed two-cycle latency.
// CPU accesses use the free RAM slots. The whole array is swept to CLEAR_WORD after every reset.
module vga_text_vram #(
  parameter int          ADDR_W     = 11,
  parameter logic [15:0] CLEAR_WORD = 16'h0720
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [15:0]       disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_be,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              clearing
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    WAIT,
    RESP
  } cpu_state_t;

  cpu_state_t        state, state_nxt;
  logic              capture, cpu_issue;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_be;
  logic [15:0]       req_wdata;

  logic [ADDR_W-1:0] clr_ptr;

  logic              ram_en, ram_we;
  logic [1:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_q;
  logic [15:0]       mem [DEPTH];

  logic              d1_valid, d1_clr;

  // Clear sweep: one CLEAR_WORD write per cycle, and the flag drops after the last address.
  // NOTE: sequential state is always assigned with <=, so every register samples pre-edge values.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      clearing <= 1'b1;
      clr_ptr  <= '0;
    end else if (clearing) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
      if (clr_ptr == '1) clearing <= 1'b0;
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    cpu_issue = 1'b0;
    case (state)
      IDLE: if (cpu_req && !clearing) begin
        capture   = 1'b1;
        state_nxt = PEND;
      end
      PEND: if (!disp_req && !clearing) begin
        cpu_issue = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_ack = (state == RESP);

  // The request is frozen at capture, so later cpu_* changes cannot disturb an access already in flight.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_be    <= 2'b00;
      req_wdata <= '0;
      cpu_rdata <= '0;
    end else begin
      if (capture) begin
        req_we    <= cpu_we;
        req_addr  <= cpu_addr;
        req_be    <= cpu_be;
        req_wdata <= cpu_wdata;
      end
      if (state == WAIT && !req_we) cpu_rdata <= ram_q;
    end
  end

  // Single RAM port. Slot priority: clear sweep, then display, then CPU.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 2'b00;
    ram_addr  = disp_addr;
    ram_wdata = CLEAR_WORD;
    if (clearing) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_be   = 2'b11;
      ram_addr = clr_ptr;
    end else if (disp_req) begin
      ram_en = 1'b1;
    end else if (cpu_issue) begin
      ram_en    = 1'b1;
      ram_we    = req_we;
      ram_be    = req_be;
      ram_addr  = req_addr;
      ram_wdata = req_wdata;
    end
  end

  // NOTE: the array and its read register have no reset; the clear sweep initialises the contents.
  always_ff @(posedge clk_vga) begin
    if (ram_en) begin
      if (ram_we) begin
        if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
        if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
      end else begin
        ram_q <= mem[ram_addr];
      end
    end
  end

  // Display path: request, RAM read, output register. Fetches made while clearing bypass the RAM.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      d1_valid   <= 1'b0;
      d1_clr     <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else begin
      d1_valid   <= disp_req;
      d1_clr     <= clearing;
      disp_valid <= d1_valid;
      if (d1_valid) disp_data <= d1_clr ? CLEAR_WORD : ram_q;
    end
  end

endmodule

// File: tb/tb_vga_text_vram.sv
// Directed bench for vga_text_vram. Display and CPU read results are checked against scoreboard queues.
module tb_vga_text_vram;

  localparam int ADDR_W = 11;

  logic              clk_vga = 1'b0;
  logic              rst_n;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic [15:0]       disp_data;
  logic              disp_valid;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [1:0]        cpu_be = 2'b00;
  logic [15:0]       cpu_wdata = '0;
  logic [15:0]       cpu_rdata;
  logic              cpu_ack;
  logic              clearing;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } disp_exp_t;

  disp_exp_t   disp_q[$];
  logic [15:0] cpu_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        due;
  disp_exp_t   e;

  vga_text_vram #(.ADDR_W(ADDR_W), .CLEAR_WORD(16'h0720)) dut (
    .clk_vga   (clk_vga),
    .rst_n     (rst_n),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_be    (cpu_be),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .clearing  (clearing)
  );

  always #5 clk_vga = ~clk_vga;
  always @(posedge clk_vga) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Display monitor: a fetch driven at cycle c must show up at cycle c+2, and disp_valid must be idle otherwise.
  always @(negedge clk_vga) begin
    if (rst_n === 1'b1) begin
      due = (disp_q.size() > 0) && (disp_q[0].cyc == cyc);
      if (due || disp_valid !== 1'b0) begin
        check("disp_valid", 32'(disp_valid), 32'(due));
        if (due) begin
          e = disp_q.pop_front();
          check("disp_data", 32'(disp_data), 32'(e.data));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_vga);
  endtask

  task automatic disp_fetch(input logic [ADDR_W-1:0] a, input logic [15:0] exp);
    disp_req  = 1'b1;
    disp_addr = a;
    disp_q.push_back('{exp, cyc + 2});
    @(negedge clk_vga);
    disp_req = 1'b0;
  endtask

  task automatic wait_ack(input int c0, input logic we, input int exp_lat, input string tag);
    logic [15:0] exp_rd;
    while (cpu_ack !== 1'b1 && (cyc - c0) < 40) @(negedge clk_vga);
    check({tag, " ack_latency"}, cyc - c0, exp_lat);
    cpu_req = 1'b0;
    if (!we) begin
      exp_rd = cpu_q.pop_front();
      check({tag, " rdata"}, 32'(cpu_rdata), 32'(exp_rd));
    end
  endtask

  // Drives a request. The inputs are then scrambled one cycle later, after the DUT has captured them.
  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input logic [15:0] exp_rd, input int exp_lat,
                        input string tag);
    int c0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_be    = be;
    cpu_wdata = wd;
    if (!we) cpu_q.push_back(exp_rd);
    c0 = cyc;
    @(negedge clk_vga);
    cpu_we    = ~we;
    cpu_addr  = ~a;
    cpu_be    = ~be;
    cpu_wdata = ~wd;
    wait_ack(c0, we, exp_lat, tag);
  endtask

  // Counts the clearing cycles, and fetches the top cell part-way through the sweep.
  task automatic sweep(input string tag);
    int   n = 0;
    logic ack_seen = 1'b0;
    while (clearing === 1'b1 && n < 3000) begin
      @(negedge clk_vga);
      n++;
      ack_seen = ack_seen | cpu_ack;
      if (n == 100) begin
        disp_req  = 1'b1;
        disp_addr = 11'h7FF;
        disp_q.push_back('{16'h0720, cyc + 2});
      end else begin
        disp_req = 1'b0;
      end
    end
    check({tag, " clear_cycles"}, n, 2048);
    check({tag, " no_ack_while_clearing"}, 32'(ack_seen), 32'd0);
  endtask

  initial begin
    logic ack_seen;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    idle(2);
    check("rst disp_data", 32'(disp_data), 32'h0);
    check("rst disp_valid", 32'(disp_valid), 32'h0);
    check("rst cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("rst cpu_ack", 32'(cpu_ack), 32'h0);
    check("rst clearing", 32'(clearing), 32'h1);

    // Power-on clear, then fetch the first and last visible cells.
    rst_n = 1'b1;
    sweep("t1");
    disp_fetch(11'h000, 16'h0720);
    disp_fetch(11'h7CF, 16'h0720);

    // Full write; a display fetch in the ack cycle must see it.
    cpu_op(1'b1, 11'h005, 2'b11, 16'h1F41, 16'h0, 3, "t2_wr");
    disp_fetch(11'h005, 16'h1F41);
    check("ack_one_cycle", 32'(cpu_ack), 32'h0);

    // Low-byte write, then read back.
    cpu_op(1'b1, 11'h005, 2'b01, 16'h2242, 16'h0, 3, "t3_wr");
    idle(1);
    cpu_op(1'b0, 11'h005, 2'b00, 16'h0000, 16'h1F42, 3, "t3_rd");
    idle(1);

    // Byte-enable corners and the top address.
    cpu_op(1'b1, 11'h005, 2'b00, 16'hFFFF, 16'h0, 3, "be00_wr");
    disp_fetch(11'h005, 16'h1F42);
    cpu_op(1'b1, 11'h006, 2'b10, 16'h3300, 16'h0, 3, "be10_wr");
    disp_fetch(11'h006, 16'h3320);
    cpu_op(1'b1, 11'h7FF, 2'b11, 16'hBEEF, 16'h0, 3, "top_wr");
    disp_fetch(11'h7FF, 16'hBEEF);
    check("rdata_hold", 32'(cpu_rdata), 32'h1F42);

    // A CPU read stalled by five back-to-back display fetches.
    fork
      cpu_op(1'b0, 11'h005, 2'b00, 16'h0000, 16'h1F42, 8, "t4_rd");
      begin
        @(negedge clk_vga);
        disp_fetch(11'h005, 16'h1F42);
        disp_fetch(11'h006, 16'h3320);
        disp_fetch(11'h000, 16'h0720);
        disp_fetch(11'h7FF, 16'hBEEF);
        disp_fetch(11'h001, 16'h0720);
      end
    join
    idle(1);

    // Reset while a write waits in PEND behind display fetches.
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 11'h020;
    cpu_be    = 2'b11;
    cpu_wdata = 16'h5555;
    disp_fetch(11'h000, 16'h0720);
    disp_fetch(11'h001, 16'h0720);
    rst_n    = 1'b0;
    disp_req = 1'b0;
    cpu_req  = 1'b0;
    disp_q.delete();
    #1;
    check("t6 rst disp_valid", 32'(disp_valid), 32'h0);
    check("t6 rst disp_data", 32'(disp_data), 32'h0);
    check("t6 rst cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("t6 rst clearing", 32'(clearing), 32'h1);
    ack_seen = cpu_ack;
    repeat (3) begin
      @(negedge clk_vga);
      ack_seen = ack_seen | cpu_ack;
    end
    check("t6 no_ack_in_reset", 32'(ack_seen), 32'h0);

    // Request held through the restarted sweep; it is captured once clearing drops.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 11'h7FF;
    cpu_q.push_back(16'h0720);
    rst_n = 1'b1;
    sweep("t5");
    wait_ack(cyc, 1'b0, 3, "t5_rd");
    disp_fetch(11'h000, 16'h0720);
    disp_fetch(11'h005, 16'h0720);
    disp_fetch(11'h020, 16'h0720);
    idle(4);

    check("disp_queue_drained", disp_q.size(), 0);
    check("cpu_queue_drained", cpu_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
